// File: rtl/ro_pkg.sv
// Shared types and constants for the round-robin readout scheduler.
package ro_pkg;

  localparam int DEF_NCH = 8;
  localparam int DEF_IDW = 3;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ID,
    DATA,
    STOP
  } state_t;

  // START + ID bits + DATA + STOP
  function automatic int pkt_len(input int idw);
    return idw + 3;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after the last-granted index.
module rr_arbiter
  import ro_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int IDW = DEF_IDW
) (
  input  logic [NCH-1:0] req,
  input  logic [IDW-1:0] last,
  output logic           valid,
  output logic [NCH-1:0] win,
  output logic [IDW-1:0] idx
);

  always_comb begin
    int ci;
    logic [IDW-1:0] c;
    valid = 1'b0;
    win   = '0;
    idx   = '0;
    ci    = 0;
    c     = '0;
    for (int k = 1; k <= NCH; k++) begin
      ci = (int'(last) + k) % NCH;
      c  = IDW'(ci);
      if (!valid && req[c]) begin
        valid  = 1'b1;
        win[c] = 1'b1;
        idx    = c;
      end
    end
  end

endmodule

// File: rtl/ro_scheduler.sv
// Event-driven readout scheduler: buffers one sample per channel and serialises
// START/ID/DATA/STOP packets. Define RO_OVF_CNT_EN to add the saturating ovf_cnt output.
module ro_scheduler
  import ro_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int IDW   = DEF_IDW,
  parameter int OVF_W = 8
) (
  input  logic             clk_ext,
  input  logic             rstb,
  input  logic             enable,
  input  logic [NCH-1:0]   ev_valid,
  input  logic [NCH-1:0]   ev_data,
  output logic             out,
  output logic             busy,
  output logic             frame_start,
  output logic [NCH-1:0]   grant,
  output logic [NCH-1:0]   ovf_flag
`ifdef RO_OVF_CNT_EN
  ,
  output logic [OVF_W-1:0] ovf_cnt
`endif
);

  state_t           state;
  logic [NCH-1:0]   pend;
  logic [NCH-1:0]   hold;
  logic [IDW-1:0]   last;
  logic [IDW-1:0]   cnt;
  logic [IDW-1:0]   chan_id;
  logic             data_bit;

  logic             arb_valid;
  logic [NCH-1:0]   arb_win;
  logic [IDW-1:0]   arb_idx;
  logic             arb_go;
  logic [NCH-1:0]   clr;
  logic [NCH-1:0]   drop;

  rr_arbiter #(
    .NCH (NCH),
    .IDW (IDW)
  ) u_arb (
    .req   (pend),
    .last  (last),
    .valid (arb_valid),
    .win   (arb_win),
    .idx   (arb_idx)
  );

  assign arb_go = enable && arb_valid && (state == IDLE || state == STOP);
  assign clr    = arb_go ? arb_win : '0;
  // A strobe landing on the channel being granted this cycle refills the buffer.
  assign drop   = ev_valid & pend & ~clr;

  always_ff @(posedge clk_ext) begin
    if (!rstb) begin
      pend     <= '0;
      ovf_flag <= '0;
    end else begin
      pend     <= (pend & ~clr) | ev_valid;
      ovf_flag <= ovf_flag | drop;
    end
  end

  always_ff @(posedge clk_ext) begin
    for (int i = 0; i < NCH; i++) begin
      if (ev_valid[i] && (!pend[i] || clr[i])) hold[i] <= ev_data[i];
    end
    if (arb_go) begin
      chan_id  <= arb_idx;
      data_bit <= hold[arb_idx];
    end
  end

  // Outputs are registered with the state so out/grant/busy/frame_start stay aligned.
  always_ff @(posedge clk_ext) begin
    if (!rstb) begin
      state       <= IDLE;
      last        <= IDW'(NCH - 1);
      cnt         <= '0;
      out         <= 1'b0;
      busy        <= 1'b0;
      frame_start <= 1'b0;
      grant       <= '0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE, STOP: begin
          if (arb_go) begin
            state       <= START;
            last        <= arb_idx;
            out         <= START_BIT;
            busy        <= 1'b1;
            frame_start <= 1'b1;
            grant       <= arb_win;
          end else begin
            state <= IDLE;
            out   <= 1'b0;
            busy  <= 1'b0;
            grant <= '0;
          end
        end
        START: begin
          state <= ID;
          cnt   <= IDW'(IDW - 1);
          out   <= chan_id[IDW-1];
        end
        ID: begin
          if (cnt == '0) begin
            state <= DATA;
            out   <= data_bit;
          end else begin
            cnt <= cnt - 1'b1;
            out <= chan_id[cnt - 1'b1];
          end
        end
        DATA: begin
          state <= STOP;
          out   <= STOP_BIT;
        end
        default: begin
          state <= IDLE;
          out   <= 1'b0;
          busy  <= 1'b0;
          grant <= '0;
        end
      endcase
    end
  end

`ifdef RO_OVF_CNT_EN
  function automatic logic [IDW:0] popcount(input logic [NCH-1:0] v);
    logic [IDW:0] n;
    n = '0;
    for (int i = 0; i < NCH; i++) n = n + {{IDW{1'b0}}, v[i]};
    return n;
  endfunction

  function automatic logic [OVF_W-1:0] sat_add(input logic [OVF_W-1:0] a,
                                               input logic [IDW:0]     b);
    logic [OVF_W:0] s;
    s = {1'b0, a} + (OVF_W + 1)'(b);
    return s[OVF_W] ? '1 : s[OVF_W-1:0];
  endfunction

  always_ff @(posedge clk_ext) begin
    if (!rstb) ovf_cnt <= '0;
    else       ovf_cnt <= sat_add(ovf_cnt, popcount(drop));
  end
`endif

endmodule

// File: doc/ro_scheduler.md
# ro_scheduler

Round-robin readout scheduler that shares the single serial readout line between the NCH octave-band channels of the cochlea readout. Each channel posts a 1-bit sample with a strobe. The block buffers one sample per channel and arbitrates among pending channels. It serializes each granted sample as a fixed-length packet carrying the channel ID. It replaces free-running time-slot muxing of the output bus with event-driven, collision-free scheduling, and drives a one-hot grant compatible with the existing output-bus control.

## Interface
- NCH, 8, number of channels
- IDW, 3, channel ID width; must equal clog2(NCH)
- OVF_W, 8, overflow counter width

- clk_ext  in  1  single system clock; all logic on rising edge
- rstb  in  1  synchronous, active-low reset
- enable  in  1  allows new arbitration; does not abort a packet in flight
- ev_valid  in  NCH  per-channel single-cycle sample strobe
- ev_data  in  NCH  sample bit, sampled when ev_valid[i]=1
- out  out  1  registered serial packet line; idles at 0
- busy  out  1  packet in progress (state != IDLE)
- frame_start  out  1  high during the START bit cycle
- grant  out  NCH  one-hot channel being transmitted; 0 when idle
- ovf_flag  out  NCH  sticky per-channel drop flag
- ovf_cnt  out  OVF_W  total dropped samples (only with RO_OVF_CNT_EN)

## Operation
- Each channel has a 1-deep buffer with pend[i] and hold[i].
- ev_valid[i] with pend[i]=0: load hold[i]=ev_data[i] and set pend[i].
- ev_valid[i] with pend[i]=1 and no grant-clear this cycle: drop the new sample (old sample is kept), set ovf_flag[i], increment ovf_cnt.
- ev_valid[i] in the same cycle that arbitration clears pend[i]: load the new sample, pend[i] stays 1, no overflow.
- Packet format, MSB first, PKT_LEN = IDW+3 bits:
  - START = 1
  - ID[IDW-1:0]
  - DATA
  - STOP = 0
- FSM states: IDLE, START, ID, DATA, STOP.
  - Arbitration happens in IDLE and in the STOP cycle, gated by enable and |pend.
  - On a win: latch channel index and hold bit, clear pend[win], next state START.
  - From STOP with nothing pending or enable=0: go to IDLE.
  - ID state lasts IDW cycles, counted by a down-counter.
- Round robin:
  - Search order is last+1, last+2, … mod NCH; last = last granted index.
  - After reset, last = NCH-1, so channel 0 has first priority.
- grant is held one-hot across all PKT_LEN packet cycles.
- enable falling mid-packet: the packet completes, then IDLE; pend bits are retained.
- ovf_flag and ovf_cnt clear only on reset. ovf_cnt saturates at 2^OVF_W-1.

## Timing
- Reset values: out=0, busy=0, frame_start=0, grant=0, ovf_flag=0, ovf_cnt=0, pend=0, state=IDLE, last=NCH-1.
- Reset mid-packet: all outputs take reset values on the next edge; the packet is truncated.
- Latency when idle:
  - ev_valid at cycle 0, pend visible at cycle 1.
  - Arbitration at cycle 1.
  - START on out at cycle 2, STOP at cycle 2+PKT_LEN-1.
- Back-to-back packets leave no idle gap: the next START immediately follows STOP, giving one packet per PKT_LEN cycles (6 at defaults).
- out, grant, busy and frame_start are all registered and cycle-aligned with each other.
- ev_valid for multiple channels in the same cycle is legal; all are buffered independently.

## Configuration
- RO_OVF_CNT_EN defined: the ovf_cnt port and saturating OVF_W counter exist.
  - When several channels drop in the same cycle, the counter adds the number of drops, saturating.
- RO_OVF_CNT_EN undefined: no ovf_cnt port and no counter logic; ovf_flag behaviour is unchanged.

## Structure
- Package ro_pkg holds:
  - FSM state enum (IDLE, START, ID, DATA, STOP)
  - START_BIT=1 and STOP_BIT=0
  - PKT_LEN function of IDW
  - default NCH/IDW
- Sub-module rr_arbiter:
  - inputs: NCH request vector, last-pointer
  - outputs: valid flag, one-hot win, binary index
  - purely combinational; the pointer register lives in ro_scheduler.
- Top contains the channel buffers, FSM, shift/bit counter, output registers and the optional counter.

## Test plan
- Reset: hold rstb=0 for 2 cycles with random ev_valid → out=0, busy=0, grant=0, ovf_flag=0, no packet afterwards.
- Single event: ch5 with ev_data=1 at cycle 0, enable=1 → out over cycles 2–7 = 1,1,0,1,1,0; grant=8'h20 over cycles 2–7; frame_start only at cycle 2; busy falls at cycle 8.
- All channels at once: ev_valid=8'hFF with ev_data=8'hA5 → 8 back-to-back packets with IDs 0..7 in order, DATA bits 1,0,1,0,0,1,0,1, over 48 cycles with no gap.
- Overflow:
  - ch3 strobed three times during ch0's packet → one packet for ch3 carrying the first sample; ovf_flag=8'h08; ovf_cnt=2 with the macro.
  - ch3 strobed in its own arbitration cycle → second packet sent, no overflow.
- Control mid-packet:
  - enable dropped during ID bits with ch1 pending → current packet finishes, ch1 waits; ch1's packet starts 1 cycle after enable returns.
  - rstb=0 during DATA → out=0 and grant=0 next cycle.
